// File: rtl/byte_frame_receiver.sv
// Byte-bus frame receiver: hunts for SOF, parses length/payload/checksum, flags pass/fail.
// Optional frame/error statistics counters when BYTE_FRAME_RECEIVER_STATS_EN is defined.
module byte_frame_receiver #(
  parameter logic [7:0] SOF     = 8'h42,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  a,
  input  logic        a_vld,
  output logic [7:0]  pay_data,
  output logic        pay_vld,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
`ifdef BYTE_FRAME_RECEIVER_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LEN, PAY, CHK} state_t;

  localparam logic [7:0] MAX_LEN_B   = MAX_LEN[7:0];
  localparam logic [7:0] IDLE_LIMIT  = 8'(TIMEOUT - 1);
  localparam logic [1:0] CODE_LEN    = 2'd1;
  localparam logic [1:0] CODE_CHK    = 2'd2;
  localparam logic [1:0] CODE_TMO    = 2'd3;

  // Checksum accumulation wraps modulo 256; the carry is intentionally dropped.
  function automatic logic [7:0] add_wrap8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[7:0];
  endfunction

  state_t     state, state_nxt;
  logic [7:0] len_cnt, len_nxt;
  logic [7:0] sum, sum_nxt;
  logic [7:0] idle_cnt, idle_nxt;
  logic [7:0] pay_data_nxt;
  logic       pay_vld_nxt, ok_nxt, err_nxt;
  logic [1:0] code_nxt;

  always_comb begin
    state_nxt    = state;
    len_nxt      = len_cnt;
    sum_nxt      = sum;
    idle_nxt     = idle_cnt;
    pay_data_nxt = pay_data;
    pay_vld_nxt  = 1'b0;
    ok_nxt       = 1'b0;
    err_nxt      = 1'b0;
    code_nxt     = err_code;

    if (state == IDLE) begin
      idle_nxt = 8'd0;
      if (a_vld && (a == SOF)) begin
        state_nxt = LEN;
        sum_nxt   = 8'd0;
      end
    end else if (!a_vld) begin
      // Consecutive idle cycles inside a frame; the TIMEOUT-th one aborts it.
      if (idle_cnt == IDLE_LIMIT) begin
        state_nxt = IDLE;
        idle_nxt  = 8'd0;
        err_nxt   = 1'b1;
        code_nxt  = CODE_TMO;
      end else begin
        idle_nxt = idle_cnt + 8'd1;
      end
    end else begin
      idle_nxt = 8'd0;
      case (state)
        LEN: begin
          if (a > MAX_LEN_B) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
            code_nxt  = CODE_LEN;
          end else if (a == 8'd0) begin
            state_nxt = CHK;
            sum_nxt   = 8'd0;
          end else begin
            state_nxt = PAY;
            len_nxt   = a;
            sum_nxt   = a;
          end
        end
        PAY: begin
          pay_data_nxt = a;
          pay_vld_nxt  = 1'b1;
          sum_nxt      = add_wrap8(sum, a);
          len_nxt      = len_cnt - 8'd1;
          if (len_cnt == 8'd1) state_nxt = CHK;
        end
        CHK: begin
          state_nxt = IDLE;
          if (a == sum) begin
            ok_nxt = 1'b1;
          end else begin
            err_nxt  = 1'b1;
            code_nxt = CODE_CHK;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_cnt   <= 8'd0;
      sum       <= 8'd0;
      idle_cnt  <= 8'd0;
      pay_data  <= 8'h00;
      pay_vld   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_cnt   <= len_nxt;
      sum       <= sum_nxt;
      idle_cnt  <= idle_nxt;
      pay_data  <= pay_data_nxt;
      pay_vld   <= pay_vld_nxt;
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      err_code  <= code_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef BYTE_FRAME_RECEIVER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Counters advance on the same edge that raises the matching pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      if (ok_nxt)  frame_cnt <= sat_inc16(frame_cnt);
      if (err_nxt) err_cnt   <= sat_inc16(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_byte_frame_receiver.sv
// Scoreboard bench for byte_frame_receiver: expected payload bytes and frame events are queued
// as stimulus is driven and consumed when the DUT pulses pay_vld / frame_ok / frame_err.
module tb_byte_frame_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a;
  logic        a_vld;
  logic [7:0]  pay_data;
  logic        pay_vld;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
`ifdef BYTE_FRAME_RECEIVER_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       ok;
    logic [1:0] code;
  } ev_t;

  logic [7:0] pay_q[$];
  ev_t        ev_q[$];

  byte_frame_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .a_vld     (a_vld),
    .pay_data  (pay_data),
    .pay_vld   (pay_vld),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
`ifdef BYTE_FRAME_RECEIVER_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    ev_t        exp_e;
    if (pay_vld === 1'b1) begin
      total++;
      if (pay_q.size() == 0) begin
        bad++;
        $display("FAIL pay_unexpected got=%h expected=none", pay_data);
      end else begin
        exp_b = pay_q.pop_front();
        if (pay_data !== exp_b) begin
          bad++;
          $display("FAIL pay_data got=%h expected=%h", pay_data, exp_b);
        end
      end
    end
    if (frame_ok === 1'b1 && frame_err === 1'b1) begin
      total++;
      bad++;
      $display("FAIL ok_err_same_cycle got=11 expected=not both");
    end else if (frame_ok === 1'b1 || frame_err === 1'b1) begin
      total++;
      if (ev_q.size() == 0) begin
        bad++;
        $display("FAIL event_unexpected got ok=%b err=%b code=%0d expected=none",
                 frame_ok, frame_err, err_code);
      end else begin
        exp_e = ev_q.pop_front();
        if (exp_e.ok && frame_ok !== 1'b1) begin
          bad++;
          $display("FAIL event_kind got err code=%0d expected=ok", err_code);
        end else if (!exp_e.ok && (frame_err !== 1'b1 || err_code !== exp_e.code)) begin
          bad++;
          $display("FAIL event_err got ok=%b err=%b code=%0d expected err code=%0d",
                   frame_ok, frame_err, err_code, exp_e.code);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    a     = b;
    a_vld = 1'b1;
    @(posedge clk);
    #1;
    a_vld = 1'b0;
    a     = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ok();
    ev_t e;
    e.ok = 1'b1; e.code = 2'd0;
    ev_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    ev_t e;
    e.ok = 1'b0; e.code = code;
    ev_q.push_back(e);
  endtask

  task automatic drain(input string name);
    idle(2);
    total++;
    if (pay_q.size() != 0 || ev_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got pay_left=%0d ev_left=%0d expected=0 0",
               name, pay_q.size(), ev_q.size());
      pay_q.delete();
      ev_q.delete();
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    a     = 8'h42;
    a_vld = 1'b1;
    idle(3);
    a_vld = 1'b0;
    a     = 8'h00;
    total++;
    if ({pay_data, pay_vld, frame_ok, frame_err, err_code, busy} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs got data=%h vld=%b ok=%b err=%b code=%0d busy=%b expected=all 0",
               pay_data, pay_vld, frame_ok, frame_err, err_code, busy);
    end
`ifdef BYTE_FRAME_RECEIVER_STATS_EN
    total++;
    if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_counters got %0d %0d expected=0 0", frame_cnt, err_cnt);
    end
`endif
    rst = 1'b0;
    idle(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_sof_ignored busy got=%b expected=0", busy);
    end
  endtask

  task automatic test_good_frame();
    pay_q.push_back(8'h11);
    pay_q.push_back(8'h22);
    push_ok();
    send(8'h42);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL good_busy got=%b expected=1", busy);
    end
    send(8'h02); send(8'h11); send(8'h22); send(8'h35);
    total++;
    if (frame_ok !== 1'b1 || err_code !== 2'd0) begin
      bad++;
      $display("FAIL good_frame_ok got ok=%b code=%0d expected ok=1 code=0", frame_ok, err_code);
    end
    drain("good");
  endtask

  task automatic test_bad_checksum();
    pay_q.push_back(8'h11);
    pay_q.push_back(8'h22);
    push_err(2'd2);
    send(8'h42); send(8'h02); send(8'h11); send(8'h22); send(8'h36);
    total++;
    if (frame_err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL badsum got err=%b code=%0d busy=%b expected err=1 code=2 busy=0",
               frame_err, err_code, busy);
    end
    drain("badsum");
  endtask

  task automatic test_length();
    logic [7:0] s;
    push_err(2'd1);
    send(8'h42); send(8'h11);
    total++;
    if (frame_err !== 1'b1 || err_code !== 2'd1) begin
      bad++;
      $display("FAIL len_err got err=%b code=%0d expected err=1 code=1", frame_err, err_code);
    end
    push_ok();
    send(8'h42); send(8'h00); send(8'h00);
    total++;
    if (frame_ok !== 1'b1) begin
      bad++;
      $display("FAIL len_zero got ok=%b expected=1", frame_ok);
    end
    // Largest legal length, checksum computed here with 8-bit wrap.
    s = 8'd16;
    push_ok();
    send(8'h42); send(8'd16);
    for (int i = 1; i <= 16; i++) begin
      pay_q.push_back(8'(i));
      s = s + 8'(i);
      send(8'(i));
    end
    send(s);
    total++;
    if (frame_ok !== 1'b1) begin
      bad++;
      $display("FAIL len_max got ok=%b expected=1", frame_ok);
    end
    drain("length");
  endtask

  task automatic test_timeout();
    pay_q.push_back(8'hAA);
    send(8'h42); send(8'h03); send(8'hAA);
    idle(7);
    total++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early got err=%b busy=%b expected err=0 busy=1", frame_err, busy);
    end
    push_err(2'd3);
    idle(1);
    total++;
    if (frame_err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout got err=%b code=%0d busy=%b expected err=1 code=3 busy=0",
               frame_err, err_code, busy);
    end
    pay_q.push_back(8'h05);
    push_ok();
    send(8'h42); send(8'h01); send(8'h05); send(8'h06);
    total++;
    if (frame_ok !== 1'b1 || err_code !== 2'd3) begin
      bad++;
      $display("FAIL timeout_recover got ok=%b code=%0d expected ok=1 code=3", frame_ok, err_code);
    end
    drain("timeout");
  endtask

  task automatic test_noise_wrap();
    send(8'h00); send(8'hFF); send(8'h13);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL noise_busy got=%b expected=0", busy);
    end
    pay_q.push_back(8'hFF);
    pay_q.push_back(8'h02);
    push_err(2'd2);
    send(8'h42); send(8'h02); send(8'hFF); send(8'h02); send(8'h01);
    total++;
    if (frame_err !== 1'b1 || err_code !== 2'd2) begin
      bad++;
      $display("FAIL wrap_err got err=%b code=%0d expected err=1 code=2", frame_err, err_code);
    end
    pay_q.push_back(8'hFF);
    pay_q.push_back(8'h02);
    push_ok();
    send(8'h42); send(8'h02); send(8'hFF); send(8'h02); send(8'h03);
    total++;
    if (frame_ok !== 1'b1) begin
      bad++;
      $display("FAIL wrap_ok got ok=%b expected=1", frame_ok);
    end
    drain("noise");
  endtask

  task automatic test_back_to_back();
    // Second frame starts right after the first checksum; SOF value also appears as payload.
    pay_q.push_back(8'h42);
    push_ok();
    pay_q.push_back(8'h07);
    push_ok();
    send(8'h42); send(8'h01); send(8'h42); send(8'h43);
    total++;
    if (frame_ok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got ok=%b expected=1", frame_ok);
    end
    send(8'h42); send(8'h01); send(8'h07); send(8'h08);
    total++;
    if (frame_ok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got ok=%b expected=1", frame_ok);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid_frame();
    pay_q.push_back(8'h10);
    send(8'h42); send(8'h04); send(8'h10);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    total++;
    if ({pay_data, pay_vld, frame_ok, frame_err, err_code, busy} !== 14'h0) begin
      bad++;
      $display("FAIL midrst_outputs got data=%h vld=%b ok=%b err=%b code=%0d busy=%b expected=all 0",
               pay_data, pay_vld, frame_ok, frame_err, err_code, busy);
    end
    pay_q.push_back(8'h07);
    push_ok();
    send(8'h42); send(8'h01); send(8'h07); send(8'h08);
    total++;
    if (frame_ok !== 1'b1) begin
      bad++;
      $display("FAIL midrst_second got ok=%b expected=1", frame_ok);
    end
`ifdef BYTE_FRAME_RECEIVER_STATS_EN
    total++;
    if (frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      bad++;
      $display("FAIL midrst_counters got %0d %0d expected=1 0", frame_cnt, err_cnt);
    end
`endif
    drain("midrst");
  endtask

  initial begin
    rst   = 1'b1;
    a     = 8'h00;
    a_vld = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length();
    test_timeout();
    test_noise_wrap();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_frame_receiver.md
Name: byte_frame_receiver

Overview:
- Receive-side endpoint for the 8-bit byte bus `a[7:0]`. The transmitting block drives this bus from a synchronously reset register.
- Hunts for a start-of-frame marker, then parses length, payload and checksum bytes.
- Presents each payload byte on a registered output and reports frame pass/fail.
- Sits directly downstream of the byte-driving block, in place of a passive sink.

Parameters:
- SOF, 8'h42, start-of-frame marker byte.
- MAX_LEN, 16, largest legal payload length in bytes (1..255).
- TIMEOUT, 8, consecutive idle cycles inside a frame that abort it (2..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- a  input  8  incoming byte.
- a_vld  input  1  byte on `a` is valid this cycle.
- pay_data  output  8  registered payload byte.
- pay_vld  output  1  one-cycle pulse: `pay_data` is valid.
- frame_ok  output  1  one-cycle pulse: frame completed, checksum matched.
- frame_err  output  1  one-cycle pulse: frame aborted.
- err_code  output  2  reason for the last error: 1=length, 2=checksum, 3=timeout; holds until the next error.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset values: pay_data=8'h0, pay_vld=0, frame_ok=0, frame_err=0, err_code=2'h0, busy=0. State=IDLE, len_cnt=0, sum=0, idle_cnt=0.
- A byte is accepted on any rising edge where `a_vld`=1. Cycles with `a_vld`=0 carry no data.
- IDLE:
  - Accepted byte == SOF -> LEN, with sum cleared.
  - Any other byte is discarded.
  - Idle cycles are ignored.
- LEN, on an accepted byte L:
  - L > MAX_LEN -> frame_err=1 and err_code=1 next cycle; state -> IDLE.
  - L == 0 -> CHK with sum=0.
  - Otherwise -> PAY with len_cnt=L and sum=L.
- PAY, on each accepted byte:
  - pay_data=byte and pay_vld=1 on the following cycle (latency 1).
  - sum = sum + byte, mod 256 (8-bit wrap, carry discarded).
  - len_cnt decrements; when it reaches 0 -> CHK.
- CHK, on accepted byte C:
  - C == sum -> frame_ok=1 next cycle.
  - Otherwise -> frame_err=1 and err_code=2 next cycle.
  - Either way, state -> IDLE.
- Timeout:
  - In LEN, PAY or CHK, idle_cnt counts consecutive cycles with `a_vld`=0 and clears on any accepted byte.
  - When idle_cnt reaches TIMEOUT -> frame_err=1 and err_code=3 next cycle; state -> IDLE.
  - idle_cnt is held at 0 in IDLE.
- SOF byte inside a frame is treated as ordinary data; no resynchronisation.
- The byte after a completed or aborted frame is evaluated in IDLE, so back-to-back frames are accepted with no gap.
- frame_ok and frame_err are never high in the same cycle.
- Reset mid-frame: state -> IDLE and all outputs take their reset values on the next edge. No error pulse is generated for the discarded frame.
- `rst` has priority over all other events, including a simultaneous `a_vld`.

Optional Feature:
- Macro: BYTE_FRAME_RECEIVER_STATS_EN.
- When defined, two extra output ports exist:
  - frame_cnt[15:0]: increments on each frame_ok.
  - err_cnt[15:0]: increments on each frame_err.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Good frame, defaults: 42 02 11 22 35 on consecutive cycles -> pay_vld pulses with 8'h11 then 8'h22; frame_ok=1 one cycle after 35; err_code stays 0.
- Bad checksum: 42 02 11 22 36 -> both payload bytes emitted; frame_err=1 with err_code=2; busy=0 the following cycle.
- Length error and zero length:
  - 42 11 (17 > MAX_LEN) -> frame_err with err_code=1; no pay_vld.
  - Then 42 00 00 -> frame_ok with no payload output.
- Timeout: 42 03 AA, then 8 idle cycles -> frame_err with err_code=3 after the 8th idle cycle. A subsequent 42 01 05 06 -> frame_ok.
- Noise and wrap: bytes 00 FF 13 ahead of 42 02 FF 02 01 -> noise ignored; sum=(02+FF+02) mod 256=8'h03, which does not equal 01 -> err_code=2. Resending with checksum 03 -> frame_ok.
- Reset mid-frame: 42 04 10, assert rst for 1 cycle, then 42 01 07 08 -> no error pulse from the first frame; outputs at reset values; second frame gives frame_ok. With the macro defined: frame_cnt=1, err_cnt=0.
